// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Memory-side responder for the byte-serial MemCtrl bus.
//             Byte-addressed RAM plus an IO window holding a UART transmit
//             FIFO, a receive-byte port and a sticky halt register.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        mem_valid,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        tx_overflow,
    output logic        halt_out
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(TX_DEPTH);
    localparam logic [CNT_W-1:0] NEAR_FULL_C  = CNT_W'(TX_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE_C    = PTR_W'(1);
    localparam logic [17:0]      TX_ADDR_C    = 18'h30000;
    localparam logic [17:0]      CTRL_ADDR_C  = 18'h30004;

    // Storage (never reset)
    logic [7:0] ram_q  [2**ADDR_WIDTH];
    logic [7:0] fifo_q [TX_DEPTH];

    // Control state
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             ovf_q, ovf_d;
    logic             halt_q, halt_d;
    logic             rx_pop_q, rx_pop_d;

    // Decode
    logic                  w_io_sel;
    logic [17:0]           w_off;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_ram_wr;
    logic                  w_ram_rd;
    logic                  w_io_rd;
    logic                  w_tx_req;
    logic                  w_halt_req;
    logic                  w_rx_req;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    // Address bits above the IO decode carry no meaning on this bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_a[31:18];

    assign w_io_sel   = (mem_a[17:16] == 2'b11);
    assign w_off      = mem_a[17:0];
    assign w_ram_idx  = mem_a[ADDR_WIDTH-1:0];
    assign w_ram_wr   = mem_valid &  mem_wr & ~w_io_sel;
    assign w_ram_rd   = mem_valid & ~mem_wr & ~w_io_sel;
    assign w_io_rd    = mem_valid & ~mem_wr &  w_io_sel;
    assign w_tx_req   = mem_valid &  mem_wr &  w_io_sel & (w_off == TX_ADDR_C);
    assign w_halt_req = mem_valid &  mem_wr &  w_io_sel & (w_off == CTRL_ADDR_C);
    assign w_rx_req   = w_io_rd & (w_off == TX_ADDR_C) & rx_valid;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_full = (count_q == DEPTH_C);
    assign w_pop  = (count_q != '0) & tx_ready;
    assign w_push = w_tx_req & (~w_full | w_pop);
    assign w_drop = w_tx_req &  w_full & ~w_pop;

    // Next-state for FIFO bookkeeping, IO read data and sticky flags
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        ovf_d    = ovf_q | w_drop;
        halt_d   = halt_q | w_halt_req;
        rx_pop_d = w_rx_req;

        if (w_push) begin
            wptr_d = wptr_q + PTR_ONE_C;
        end
        if (w_pop) begin
            rptr_d = rptr_q + PTR_ONE_C;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase

        if (w_io_rd) begin
            if (w_off == TX_ADDR_C) begin
                rdata_d = rx_valid ? rx_data : 8'h00;
            end else if (w_off == CTRL_ADDR_C) begin
                rdata_d = {5'b00000, ovf_q, rx_valid, w_full};
            end else begin
                rdata_d = 8'h00;
            end
        end
    end

    // Control registers; RAM reads land in mem_rdata one cycle after the access
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= 8'h00;
            ovf_q    <= 1'b0;
            halt_q   <= 1'b0;
            rx_pop_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            halt_q   <= halt_d;
            rx_pop_q <= rx_pop_d;
            if (w_ram_rd) begin
                rdata_q <= ram_q[w_ram_idx];
            end else begin
                rdata_q <= rdata_d;
            end
        end
    end

    // RAM write port
    always_ff @(posedge clk_in) begin
        if (w_ram_wr) begin
            ram_q[w_ram_idx] <= mem_wdata;
        end
    end

    // Transmit FIFO storage; a push during reset is harmless since pointers clear
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            fifo_q[wptr_q] <= mem_wdata;
        end
    end

    assign mem_rdata      = rdata_q;
    assign tx_valid       = (count_q != '0);
    assign tx_data        = fifo_q[rptr_q];
    assign io_buffer_full = (count_q >= NEAR_FULL_C);
    assign rx_pop         = rx_pop_q;
    assign tx_overflow    = ovf_q;
    assign halt_out       = halt_q;

endmodule
`default_nettype wire
